alu_cmd_scheduler: RTL and testbench

Shares one ArithmeticLogicUnit instance between two requesters. Each requester submits an op/argument command over a valid/ready handshake. A round-robin arbiter grants one requester at a time. An issue FSM drives the ALU, waits out its latency, captures result and status, and returns them tagged with the requester ID. Only one command is in flight at a time; the block also keeps a saturating count of ALU error responses.

---
 rtl/alu_sched_pkg.sv | 13 +
 rtl/alu_cmd_scheduler_if.sv | 35 +++
 rtl/rr_arbiter2.sv | 8 +
 rtl/alu_cmd_scheduler.sv | 95 +++++++++
 tb/tb_alu_cmd_scheduler.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU command scheduler
package alu_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef logic [1:0] op_t;
  localparam op_t OP_SUB2B   = 2'b00;
  localparam op_t OP_CMP     = 2'b01;
  localparam op_t OP_ADDCHK  = 2'b10;
  localparam op_t OP_ADDEVEN = 2'b11;
  localparam int ST_ERROR = 0;
  localparam int ST_EVEN  = 1;
  localparam int ST_ONES  = 2;
  localparam int ST_OVF   = 3;
endpackage

// File: rtl/alu_cmd_scheduler_if.sv
// alu_cmd_scheduler_if: requester, ALU and response signals of the scheduler
interface alu_cmd_scheduler_if import alu_sched_pkg::*; #(parameter int N = 8, parameter int M = 4, parameter int CNT_W = 8);
  logic [1:0] i_req_valid;
  logic [1:0] o_req_ready;
  op_t i_req0_op;
  logic [M:0] i_req0_a;
  logic [M:0] i_req0_b;
  op_t i_req1_op;
  logic [M:0] i_req1_a;
  logic [M:0] i_req1_b;
  op_t o_alu_op;
  logic [M:0] o_alu_arg_a;
  logic [M:0] o_alu_arg_b;
  logic [N:0] i_alu_result;
  logic [3:0] i_alu_status;
  logic o_rsp_valid;
  logic i_rsp_ready;
  logic o_rsp_id;
  logic [N:0] o_rsp_result;
  logic [3:0] o_rsp_status;
  logic o_busy;
  logic [CNT_W-1:0] o_err_count;
  modport slave (
    input  i_req_valid, i_req0_op, i_req0_a, i_req0_b, i_req1_op, i_req1_a, i_req1_b,
    input  i_alu_result, i_alu_status, i_rsp_ready,
    output o_req_ready, o_alu_op, o_alu_arg_a, o_alu_arg_b,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy, o_err_count
  );
  modport master (
    output i_req_valid, i_req0_op, i_req0_a, i_req0_b, i_req1_op, i_req1_a, i_req1_b,
    output i_alu_result, i_alu_status, i_rsp_ready,
    input  o_req_ready, o_alu_op, o_alu_arg_a, o_alu_arg_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy, o_err_count
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer picks the winner on contention
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);
  always_comb grant_o = (&req_i) ? {ptr_i, ~ptr_i} : req_i;
endmodule

// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler: shares one ALU between two requesters, one command in flight
module alu_cmd_scheduler import alu_sched_pkg::*; #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  alu_cmd_scheduler_if.slave bus
);
  localparam int CW = $clog2(ALU_LAT + 1);
  state_e state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_t op_q, op_d;
  logic [M:0] a_q, a_d, b_q, b_d;
  logic [N:0] res_q, res_d;
  logic [3:0] st_q, st_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [1:0] grant;
  rr_arbiter2 u_arb (.req_i(bus.i_req_valid), .ptr_i(ptr_q), .grant_o(grant));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    st_d    = st_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (|grant) begin
        state_d = S_ISSUE;
        id_d    = grant[1];
        ptr_d   = ~grant[1];
        op_d    = grant[1] ? bus.i_req1_op : bus.i_req0_op;
        a_d     = grant[1] ? bus.i_req1_a : bus.i_req0_a;
        b_d     = grant[1] ? bus.i_req1_b : bus.i_req0_b;
      end
      S_ISSUE: begin
        cnt_d   = CW'(ALU_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) begin
        res_d   = bus.i_alu_result;
        st_d    = bus.i_alu_status;
        err_d   = (bus.i_alu_status[ST_ERROR] && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      S_RESP: state_d = bus.i_rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      st_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      st_q    <= st_d;
      err_q   <= err_d;
    end
  end
  // Grant is suppressed while reset is asserted so nothing looks accepted.
  assign bus.o_req_ready  = (state_q == S_IDLE && !i_reset) ? grant : 2'b00;
  assign bus.o_alu_op     = op_q;
  assign bus.o_alu_arg_a  = a_q;
  assign bus.o_alu_arg_b  = b_q;
  assign bus.o_rsp_valid  = state_q == S_RESP;
  assign bus.o_rsp_id     = id_q;
  assign bus.o_rsp_result = res_q;
  assign bus.o_rsp_status = st_q;
  assign bus.o_busy       = state_q != S_IDLE;
  assign bus.o_err_count  = err_q;
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// tb_alu_cmd_scheduler: directed checks of the scheduler around a one-cycle ALU model
module tb_alu_cmd_scheduler;
  import alu_sched_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  alu_cmd_scheduler_if #(.N(8), .M(4), .CNT_W(8)) bus ();
  alu_cmd_scheduler #(.N(8), .M(4), .ALU_LAT(1), .CNT_W(8)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // ALU model: SUB2B = A-2B, CMP = A>B, ADDs = A+B; ADDEVEN errors on odd B
  logic [8:0] m_res;
  logic [3:0] m_st;
  always_comb begin
    m_res = (bus.o_alu_op == OP_SUB2B) ? 9'(bus.o_alu_arg_a) - 9'({bus.o_alu_arg_b, 1'b0}) :
            (bus.o_alu_op == OP_CMP)   ? 9'(bus.o_alu_arg_a > bus.o_alu_arg_b) :
                                         9'(bus.o_alu_arg_a) + 9'(bus.o_alu_arg_b);
    m_st = {(bus.o_alu_op == OP_SUB2B) && (9'(bus.o_alu_arg_a) < 9'({bus.o_alu_arg_b, 1'b0})),
            &m_res, ~m_res[0], (bus.o_alu_op == OP_ADDEVEN) && bus.o_alu_arg_b[0]};
  end
  always_ff @(posedge clk) begin
    bus.i_alu_result <= m_res;
    bus.i_alu_status <= m_st;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask
  logic [4:0] a0 [3] = '{5'd1, 5'd2, 5'd3};
  logic [4:0] a1 [3] = '{5'd5, 5'd6, 5'd7};
  int exp_res [6] = '{2, 6, 3, 7, 4, 8};
  logic exp_id [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    int i0 = 0;
    int i1 = 0;
    rst = 1'b1;
    bus.i_req_valid = 2'b11;
    bus.i_req0_op = OP_SUB2B; bus.i_req0_a = 5'd9; bus.i_req0_b = 5'd2;
    bus.i_req1_op = OP_ADDEVEN; bus.i_req1_a = 5'd4; bus.i_req1_b = 5'd3;
    bus.i_rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_rsp_id", bus.o_rsp_id, 0);
    chk("rst_rsp_result", bus.o_rsp_result, 0);
    chk("rst_rsp_status", bus.o_rsp_status, 0);
    chk("rst_alu_op", bus.o_alu_op, 0);
    chk("rst_alu_a", bus.o_alu_arg_a, 0);
    chk("rst_alu_b", bus.o_alu_arg_b, 0);
    chk("rst_err", bus.o_err_count, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst = 1'b0;
    #1;
    chk("first_grant", bus.o_req_ready, 1);
    tick();
    bus.i_req_valid = 2'b10;
    chk("issue_busy", bus.o_busy, 1);
    chk("issue_ready", bus.o_req_ready, 0);
    chk("issue_alu_a", bus.o_alu_arg_a, 9);
    chk("issue_alu_b", bus.o_alu_arg_b, 2);
    tick();
    chk("wait_rsp_valid", bus.o_rsp_valid, 0);
    tick();
    chk("sub_rsp_valid", bus.o_rsp_valid, 1);
    chk("sub_id", bus.o_rsp_id, 0);
    chk("sub_result", bus.o_rsp_result, 5);
    chk("sub_status", bus.o_rsp_status, 0);
    chk("sub_err", bus.o_err_count, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", bus.o_rsp_valid, 1);
      chk("hold_result", bus.o_rsp_result, 5);
      chk("hold_ready", bus.o_req_ready, 0);
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    chk("hs_ready", bus.o_req_ready, 0);
    tick();
    bus.i_rsp_ready = 1'b0;
    chk("idle_rsp_valid", bus.o_rsp_valid, 0);
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_alu_hold", bus.o_alu_arg_a, 9);
    chk("idle_grant1", bus.o_req_ready, 2);
    tick();
    bus.i_req_valid = 2'b00;
    chk("r1_alu_op", bus.o_alu_op, 3);
    chk("r1_alu_a", bus.o_alu_arg_a, 4);
    tick(); tick();
    chk("odd_valid", bus.o_rsp_valid, 1);
    chk("odd_id", bus.o_rsp_id, 1);
    chk("odd_result", bus.o_rsp_result, 7);
    chk("odd_status", bus.o_rsp_status, 1);
    chk("odd_err", bus.o_err_count, 1);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_req0_op = OP_ADDCHK; bus.i_req0_a = a0[0]; bus.i_req0_b = 5'd1;
    bus.i_req1_op = OP_ADDCHK; bus.i_req1_a = a1[0]; bus.i_req1_b = 5'd1;
    bus.i_req_valid = 2'b11;
    #1;
    for (int t = 0; t < 6; t++) begin
      chk("alt_grant", bus.o_req_ready, exp_id[t] ? 2 : 1);
      tick();
      if (exp_id[t]) begin
        i1++;
        if (i1 < 3) bus.i_req1_a = a1[i1]; else bus.i_req_valid[1] = 1'b0;
      end else begin
        i0++;
        if (i0 < 3) bus.i_req0_a = a0[i0]; else bus.i_req_valid[0] = 1'b0;
      end
      #1;
      chk("alt_busy_ready", bus.o_req_ready, 0);
      tick(); tick();
      chk("alt_id", bus.o_rsp_id, exp_id[t]);
      chk("alt_result", bus.o_rsp_result, exp_res[t]);
      tick();
    end
    chk("alt_idle", bus.o_busy, 0);
    bus.i_req1_op = OP_ADDEVEN; bus.i_req1_a = 5'd0; bus.i_req1_b = 5'd3;
    bus.i_req_valid = 2'b10;
    #1;
    for (int k = 0; k < 300; k++) begin
      tick(); tick(); tick();
      if (k == 0) chk("sat_first", bus.o_err_count, 2);
      if (k == 253) chk("sat_reach", bus.o_err_count, 255);
      tick();
    end
    bus.i_req_valid = 2'b00;
    chk("sat_hold", bus.o_err_count, 255);
    chk("sat_result", bus.o_rsp_result, 3);
    chk("sat_status", bus.o_rsp_status, 1);
    tick(); tick();
    chk("sat_idle", bus.o_busy, 0);
    bus.i_req0_op = OP_ADDCHK; bus.i_req0_a = 5'd2; bus.i_req0_b = 5'd3;
    bus.i_req_valid = 2'b01;
    #1;
    chk("mid_grant", bus.o_req_ready, 1);
    tick(); tick();
    chk("mid_wait_busy", bus.o_busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_valid", bus.o_rsp_valid, 0);
    chk("mid_rst_err", bus.o_err_count, 0);
    chk("mid_rst_ready", bus.o_req_ready, 0);
    chk("mid_rst_alu", bus.o_alu_arg_a, 0);
    bus.i_req0_a = 5'd6; bus.i_req0_b = 5'd6;
    rst = 1'b0;
    #1;
    chk("post_grant", bus.o_req_ready, 1);
    tick();
    bus.i_req_valid = 2'b00;
    chk("post_issue_valid", bus.o_rsp_valid, 0);
    tick(); tick();
    chk("post_valid", bus.o_rsp_valid, 1);
    chk("post_id", bus.o_rsp_id, 0);
    chk("post_result", bus.o_rsp_result, 12);
    chk("post_status", bus.o_rsp_status, 2);
    chk("post_err", bus.o_err_count, 0);
    tick();
    chk("post_idle", bus.o_busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
